// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB arbiter types and constants.
// Round-robin selection is enabled by defining CDB_RR_EN; otherwise fixed priority.
package cdb_arbiter_pkg;

    localparam int unsigned CDB_SRC_ALU  = 0;
    localparam int unsigned CDB_SRC_MUL  = 1;
    localparam int unsigned CDB_SRC_DIV  = 2;
    localparam int unsigned CDB_SRC_MEM  = 3;

    localparam int unsigned CDB_NUM_SRC  = 4;
    localparam int unsigned CDB_ROB_IX_W = 3;
    localparam int unsigned CDB_DATA_W   = 32;

    typedef struct packed {
        logic                    valid;
        logic [CDB_ROB_IX_W-1:0] rob_ix;
        logic [CDB_DATA_W-1:0]   value;
        logic [CDB_DATA_W-1:0]   dest;
    } cdb_t;

    // Index width that stays legal for a single-source configuration.
    function automatic int unsigned cdb_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_select.sv
// Combinational one-hot grant selector: round-robin from start_in when CDB_RR_EN
// is defined, otherwise a lowest-index-wins priority encoder.
module cdb_arbiter_rr_select
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC = CDB_NUM_SRC,
    parameter int unsigned IW      = cdb_idx_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_in,
    input  logic [IW-1:0]      start_in,
    output logic [NUM_SRC-1:0] grant_out,
    output logic [IW-1:0]      idx_out,
    output logic               any_out
);

    logic        w_found;
    int unsigned w_j;

`ifndef CDB_RR_EN
    logic w_unused_start;
    assign w_unused_start = ^start_in;
`endif

    always_comb begin
        grant_out = '0;
        idx_out   = '0;
        w_found   = 1'b0;
        w_j       = 0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
`ifdef CDB_RR_EN
            w_j = (32'(start_in) + k) % NUM_SRC;
`else
            w_j = k;
`endif
            if (!w_found && req_in[w_j]) begin
                w_found        = 1'b1;
                grant_out[w_j] = 1'b1;
                idx_out        = IW'(w_j);
            end
        end
        any_out = w_found;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Registered common-data-bus arbiter with per-source acknowledge and conflict counter.
// Define CDB_RR_EN for round-robin selection; default build is fixed priority.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC  = CDB_NUM_SRC,
    parameter int unsigned ROB_IX_W = CDB_ROB_IX_W,
    parameter int unsigned DATA_W   = CDB_DATA_W
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              flush_in,
    input  logic [NUM_SRC-1:0]                valid_in,
    input  logic [NUM_SRC-1:0][ROB_IX_W-1:0]  rob_ix_in,
    input  logic [NUM_SRC-1:0][DATA_W-1:0]    value_in,
    input  logic [NUM_SRC-1:0][DATA_W-1:0]    dest_in,
    output logic [NUM_SRC-1:0]                read_out,
    output logic                              cdb_valid_out,
    output logic [ROB_IX_W-1:0]               cdb_rob_ix_out,
    output logic [DATA_W-1:0]                 cdb_value_out,
    output logic [DATA_W-1:0]                 cdb_dest_out,
    output logic [15:0]                       conflict_cnt_out
);

    localparam int unsigned IW = cdb_idx_w(NUM_SRC);

    logic [NUM_SRC-1:0]  r_read;
    logic                r_cdb_valid;
    logic [ROB_IX_W-1:0] r_cdb_rob_ix;
    logic [DATA_W-1:0]   r_cdb_value;
    logic [DATA_W-1:0]   r_cdb_dest;
    logic [15:0]         r_conflict_cnt;
    logic [IW-1:0]       r_rr_ptr;

    logic [NUM_SRC-1:0]  w_elig;
    logic [NUM_SRC-1:0]  w_grant;
    logic [IW-1:0]       w_idx;
    logic                w_any;
    logic                w_conflict;

    // A source acknowledged this cycle still shows valid; mask it so it is not granted twice.
    assign w_elig     = valid_in & ~r_read;
    assign w_conflict = |(w_elig & (w_elig - NUM_SRC'(1)));

`ifndef CDB_RR_EN
    assign r_rr_ptr = '0;
`endif

    cdb_arbiter_rr_select #(
        .NUM_SRC (NUM_SRC),
        .IW      (IW)
    ) u_rr_select (
        .req_in    (w_elig),
        .start_in  (r_rr_ptr),
        .grant_out (w_grant),
        .idx_out   (w_idx),
        .any_out   (w_any)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_read         <= '0;
            r_cdb_valid    <= 1'b0;
            r_cdb_rob_ix   <= '0;
            r_cdb_value    <= '0;
            r_cdb_dest     <= '0;
            r_conflict_cnt <= '0;
`ifdef CDB_RR_EN
            r_rr_ptr       <= '0;
`endif
        end else begin
            r_read <= w_grant;
            if (w_any) begin
                r_cdb_valid  <= !flush_in;
                r_cdb_rob_ix <= rob_ix_in[w_idx];
                r_cdb_value  <= value_in[w_idx];
                r_cdb_dest   <= dest_in[w_idx];
`ifdef CDB_RR_EN
                r_rr_ptr     <= (w_idx == IW'(NUM_SRC - 1)) ? '0 : w_idx + IW'(1);
`endif
            end else begin
                r_cdb_valid <= 1'b0;
            end
            if (w_conflict && (r_conflict_cnt != '1)) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
        end
    end

    assign read_out         = r_read;
    assign cdb_valid_out    = r_cdb_valid;
    assign cdb_rob_ix_out   = r_cdb_rob_ix;
    assign cdb_value_out    = r_cdb_value;
    assign cdb_dest_out     = r_cdb_dest;
    assign conflict_cnt_out = r_conflict_cnt;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter; expectations follow CDB_RR_EN.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned RW = 3;
    localparam int unsigned DW = 32;

`ifdef CDB_RR_EN
    localparam int unsigned PAIR_FIRST = 1;
    localparam int unsigned PRE_RST_G  = 1;
    localparam int unsigned ALL4_SEQ [5] = '{0, 1, 2, 3, 0};
`else
    localparam int unsigned PAIR_FIRST = 0;
    localparam int unsigned PRE_RST_G  = 0;
    localparam int unsigned ALL4_SEQ [5] = '{0, 1, 0, 1, 0};
`endif

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       flush;
    logic [N-1:0]               valid;
    logic [N-1:0][RW-1:0]       rob;
    logic [N-1:0][DW-1:0]       value;
    logic [N-1:0][DW-1:0]       dest;
    logic [N-1:0]               read;
    logic                       cdb_valid;
    logic [RW-1:0]              cdb_rob;
    logic [DW-1:0]              cdb_value;
    logic [DW-1:0]              cdb_dest;
    logic [15:0]                cnt;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned exp_cnt;
    int unsigned g;

    always #5 clk = ~clk;

    cdb_arbiter #(
        .NUM_SRC  (N),
        .ROB_IX_W (RW),
        .DATA_W   (DW)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst_n),
        .flush_in         (flush),
        .valid_in         (valid),
        .rob_ix_in        (rob),
        .value_in         (value),
        .dest_in          (dest),
        .read_out         (read),
        .cdb_valid_out    (cdb_valid),
        .cdb_rob_ix_out   (cdb_rob),
        .cdb_value_out    (cdb_value),
        .cdb_dest_out     (cdb_dest),
        .conflict_cnt_out (cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        valid = '0;
        rob   = '0;
        value = '0;
        dest  = '0;
        step();
        step();
        check("rst_read",  32'(read),      32'h0);
        check("rst_valid", 32'(cdb_valid), 32'h0);
        check("rst_rob",   32'(cdb_rob),   32'h0);
        check("rst_value", cdb_value,      32'h0);
        check("rst_dest",  cdb_dest,       32'h0);
        check("rst_cnt",   32'(cnt),       32'h0);
        rst_n = 1'b1;
        step();
        exp_cnt = 0;

        // single MUL result
        valid[CDB_SRC_MUL] = 1'b1;
        rob[CDB_SRC_MUL]   = 3'd5;
        value[CDB_SRC_MUL] = 32'd42;
        step();
        check("mul_valid", 32'(cdb_valid), 32'h1);
        check("mul_rob",   32'(cdb_rob),   32'h5);
        check("mul_value", cdb_value,      32'd42);
        check("mul_read",  32'(read),      32'h2);
        valid[CDB_SRC_MUL] = 1'b0;
        step();
        check("mul_idle_valid", 32'(cdb_valid), 32'h0);
        check("mul_idle_read",  32'(read),      32'h0);
        check("mul_hold_value", cdb_value,      32'd42);
        check("mul_cnt",        32'(cnt),       32'h0);

        // flush with ALU request: acknowledge but no broadcast
        valid[CDB_SRC_ALU] = 1'b1;
        rob[CDB_SRC_ALU]   = 3'd1;
        value[CDB_SRC_ALU] = 32'd100;
        flush = 1'b1;
        step();
        check("flush_read",  32'(read),      32'h1);
        check("flush_valid", 32'(cdb_valid), 32'h0);
        flush = 1'b0;
        rob[CDB_SRC_ALU]   = 3'd2;
        value[CDB_SRC_ALU] = 32'd101;
        step();
        check("alu_masked_read",  32'(read),      32'h0);
        check("alu_masked_valid", 32'(cdb_valid), 32'h0);
        step();
        check("alu_new_read",  32'(read),      32'h1);
        check("alu_new_valid", 32'(cdb_valid), 32'h1);
        check("alu_new_rob",   32'(cdb_rob),   32'h2);
        check("alu_new_value", cdb_value,      32'd101);
        valid[CDB_SRC_ALU] = 1'b0;
        step();

        // ALU and MUL held together: alternate grants, one conflict cycle
        rob[CDB_SRC_ALU]   = 3'd3;
        value[CDB_SRC_ALU] = 32'd300;
        rob[CDB_SRC_MUL]   = 3'd4;
        value[CDB_SRC_MUL] = 32'd400;
        valid[CDB_SRC_ALU] = 1'b1;
        valid[CDB_SRC_MUL] = 1'b1;
        for (int unsigned e = 0; e < 4; e++) begin
            step();
            g = (e % 2 == 0) ? PAIR_FIRST : 1 - PAIR_FIRST;
            check("pair_read",  32'(read),      32'(1) << g);
            check("pair_rob",   32'(cdb_rob),   (g == 0) ? 32'd3 : 32'd4);
            check("pair_valid", 32'(cdb_valid), 32'h1);
        end
        exp_cnt = 1;
        check("pair_cnt", 32'(cnt), 32'(exp_cnt));
        valid = '0;
        step();
        check("pair_idle_read", 32'(read), 32'h0);

        // all four held; async reset between edges while broadcasting
        for (int unsigned i = 0; i < N; i++) begin
            rob[i]   = 3'(i + 4);
            value[i] = 32'(1000 + i);
            dest[i]  = (i == CDB_SRC_MEM) ? 32'h0000_A000 : 32'h0;
        end
        valid = '1;
        step();
        check("pre_rst_valid", 32'(cdb_valid), 32'h1);
        check("pre_rst_read",  32'(read),      32'(1) << PRE_RST_G);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_read",  32'(read),      32'h0);
        check("async_valid", 32'(cdb_valid), 32'h0);
        check("async_rob",   32'(cdb_rob),   32'h0);
        check("async_value", cdb_value,      32'h0);
        check("async_cnt",   32'(cnt),       32'h0);
        #2;
        rst_n = 1'b1;
        exp_cnt = 0;
        for (int unsigned e = 0; e < 5; e++) begin
            step();
            g = ALL4_SEQ[e];
            exp_cnt++;
            check("all4_read",  32'(read),      32'(1) << g);
            check("all4_valid", 32'(cdb_valid), 32'h1);
            check("all4_rob",   32'(cdb_rob),   32'(g + 4));
            check("all4_dest",  cdb_dest,       (g == CDB_SRC_MEM) ? 32'h0000_A000 : 32'h0);
            check("all4_cnt",   32'(cnt),       32'(exp_cnt));
        end

        // keep conflicting past 65535 cycles
        for (int unsigned e = 0; e < 65540; e++) begin
            step();
        end
        check("sat_cnt", 32'(cnt), 32'h0000_FFFF);
        step();
        check("sat_hold_cnt", 32'(cnt), 32'h0000_FFFF);
        valid = '0;
        step();
        check("end_read",  32'(read),      32'h0);
        check("end_valid", 32'(cdb_valid), 32'h0);
        check("end_cnt",   32'(cnt),       32'h0000_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
